gate_checker: RTL

Synthesizable response checker that sits directly downstream of the gate stimulus generator and the gate models (NOT, NAND, D flip-flop). On every rising clock edge it taps the same stimulus nets the gates receive, computes the expected gate responses, and compares them with the actual gate outputs. It accumulates per-gate mismatch counts and records the first failure. It reports a single pass/fail verdict after a fixed number of checked cycles.

---
 rtl/gate_checker.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/gate_checker.sv
// -----------------------------------------------------------------------------
// gate_checker
//
// Response checker for the NOT / NAND / D-flip-flop gate models. It taps the
// same stimulus nets as the gates, forms the expected responses, and compares
// them against the actual gate outputs once per CHECK cycle. It keeps
// saturating per-gate mismatch counts, captures the first failing compare,
// and raises done/pass after NUM_CHECKS compares.
//
// State table:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for enable; no compares, counters hold
//   S_WARMUP | letting the gates settle for WARMUP edges; no compares
//   S_CHECK  | one compare per edge; leaves on compare number NUM_CHECKS
//   S_DONE   | verdict held until reset
//
// Ports:
//   clk              in   sampling clock (same clock as the flop under test)
//   reset            in   asynchronous, active-high clear
//   enable           in   start request, sampled only in S_IDLE
//   in_not           in   NOT stimulus
//   in1_nand         in   NAND stimulus A
//   in2_nand         in   NAND stimulus B
//   D_flop           in   flip-flop D stimulus
//   out_not          in   NOT response
//   out_nand         in   NAND response
//   Q_flop           in   flip-flop Q response
//   err_not          out  NOT mismatch count (saturating)
//   err_nand         out  NAND mismatch count (saturating)
//   err_flop         out  flop mismatch count (saturating)
//   check_cnt        out  compares performed so far
//   err_any          out  sticky mismatch flag
//   first_err_cycle  out  check_cnt value at the first mismatching compare
//   first_err_mask   out  {flop, nand, not} mismatch bits of first failure
//   done             out  checking finished
//   pass             out  done & ~err_any
// -----------------------------------------------------------------------------
module gate_checker #(
    parameter int CNT_W      = 8,
    parameter int NUM_CHECKS = 4,
    parameter int WARMUP     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_not,
    input  logic             in1_nand,
    input  logic             in2_nand,
    input  logic             D_flop,
    input  logic             out_not,
    input  logic             out_nand,
    input  logic             Q_flop,
    output logic [CNT_W-1:0] err_not,
    output logic [CNT_W-1:0] err_nand,
    output logic [CNT_W-1:0] err_flop,
    output logic [CNT_W-1:0] check_cnt,
    output logic             err_any,
    output logic [CNT_W-1:0] first_err_cycle,
    output logic [2:0]       first_err_mask,
    output logic             done,
    output logic             pass
);

    // Warmup timer is a down-counter loaded with WARMUP-1 on entry, so it
    // reaches terminal count on the WARMUP-th edge spent in S_WARMUP.
    localparam int WU_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_CHK = CNT_W'(NUM_CHECKS - 1);
    localparam logic [WU_W-1:0]  WU_LOAD  = WU_W'(WARMUP - 1);
    localparam logic [WU_W-1:0]  WU_ONE   = WU_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    logic [WU_W-1:0]   r_wu_cnt;
    logic [CNT_W-1:0]  r_err_not;
    logic [CNT_W-1:0]  r_err_nand;
    logic [CNT_W-1:0]  r_err_flop;
    logic [CNT_W-1:0]  r_check_cnt;
    logic              r_err_any;
    logic [CNT_W-1:0]  r_first_err_cycle;
    logic [2:0]        r_first_err_mask;
    logic              r_done;
    logic              r_pass;
    logic              r_d_prev;
    logic              r_d_valid;

    logic              w_exp_not;
    logic              w_exp_nand;
    logic              w_exp_q;
    logic              w_mis_not;
    logic              w_mis_nand;
    logic              w_mis_flop;
    logic              w_mis_any;
    logic              w_last_chk;

    // -------------------------------------------------------------------------
    // Expected responses and mismatch bits
    // -------------------------------------------------------------------------
    assign w_exp_not  = ~in_not;
    assign w_exp_nand = ~(in1_nand & in2_nand);
    assign w_exp_q    = r_d_prev;

    assign w_mis_not  = out_not ^ w_exp_not;
    assign w_mis_nand = out_nand ^ w_exp_nand;
    // Until one D value has been captured there is no reference for Q.
    assign w_mis_flop = r_d_valid & (Q_flop ^ w_exp_q);
    assign w_mis_any  = w_mis_not | w_mis_nand | w_mis_flop;

    assign w_last_chk = (r_check_cnt == LAST_CHK);

    // -------------------------------------------------------------------------
    // One-cycle D history for the flop reference; runs in every state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d_prev  <= 1'b0;
            r_d_valid <= 1'b0;
        end else begin
            r_d_prev  <= D_flop;
            r_d_valid <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer, counters and verdict
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_wu_cnt          <= '0;
            r_err_not         <= '0;
            r_err_nand        <= '0;
            r_err_flop        <= '0;
            r_check_cnt       <= '0;
            r_err_any         <= 1'b0;
            r_first_err_cycle <= '0;
            r_first_err_mask  <= 3'b000;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state  <= S_WARMUP;
                        r_wu_cnt <= WU_LOAD;
                    end
                end

                S_WARMUP: begin
                    if (r_wu_cnt == '0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_wu_cnt <= r_wu_cnt - WU_ONE;
                    end
                end

                S_CHECK: begin
                    r_check_cnt <= r_check_cnt + CNT_ONE;

                    if (w_mis_not && (r_err_not != CNT_MAX)) begin
                        r_err_not <= r_err_not + CNT_ONE;
                    end
                    if (w_mis_nand && (r_err_nand != CNT_MAX)) begin
                        r_err_nand <= r_err_nand + CNT_ONE;
                    end
                    if (w_mis_flop && (r_err_flop != CNT_MAX)) begin
                        r_err_flop <= r_err_flop + CNT_ONE;
                    end

                    // Capture uses the pre-increment count: first compare is 0.
                    if (w_mis_any && !r_err_any) begin
                        r_err_any         <= 1'b1;
                        r_first_err_cycle <= r_check_cnt;
                        r_first_err_mask  <= {w_mis_flop, w_mis_nand, w_mis_not};
                    end

                    // The verdict must include a mismatch on this final compare.
                    if (w_last_chk) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= ~(r_err_any | w_mis_any);
                    end
                end

                S_DONE: begin
                    r_state <= S_DONE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign err_not         = r_err_not;
    assign err_nand        = r_err_nand;
    assign err_flop        = r_err_flop;
    assign check_cnt       = r_check_cnt;
    assign err_any         = r_err_any;
    assign first_err_cycle = r_first_err_cycle;
    assign first_err_mask  = r_first_err_mask;
    assign done            = r_done;
    assign pass            = r_pass;

endmodule
